sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Three-requester arbiter and sequencer for port A of the 1024x24 dual-port pixel SRAM. It accepts read and write requests from three clients over valid/ready handshakes and issues at most one registered SRAM command per cycle. Read data is returned to the issuing client with a one-hot response strobe. Requester 0 (display fetch) has fixed priority, and requesters 1 and 2 are protected by a starvation limit. Port B is not touched by this block. Cross-port address collisions are the integrator's responsibility.

## Interface
Parameters:
- ADDR_W, 10, SRAM address width
- DATA_W, 24, SRAM data width
- STARVE_LIMIT, 8, wait cycles after which requester 1 or 2 overrides requester 0 (range 1..15, 4-bit counters)

Ports:
- sram_clk  in  1  single clock, rising edge
- sram_rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  3  per-requester request valid
- req_we  in  3  per-requester write enable (1 = write, 0 = read)
- req_addr  in  3*ADDR_W  requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  3*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  3  one-hot or zero grant; combinational from req_valid and state
- rsp_valid  out  3  one-hot read-data strobe, registered
- rsp_rdata  out  DATA_W  read data, driven straight from SRAM_RDATA_A
- SRAM_CS_A_N  out  1  chip select, active-low, registered
- SRAM_WE_A_N  out  1  write enable, active-low, registered
- SRAM_ADDR_A  out  ADDR_W  registered address
- SRAM_WDATA_A  out  DATA_W  registered write data
- SRAM_RDATA_A  in  DATA_W  SRAM read data (registered inside the SRAM)

## Operation
Handshake:
- A transfer occurs in a cycle where req_valid[i] && req_ready[i].
- Requesters must hold valid, we, addr and wdata stable until accepted.
- req_ready is asserted for at most one requester per cycle, and only when that requester's valid is high.

Grant priority, evaluated each cycle:
1. Starved requesters. starved[i] is defined as wait[i]==STARVE_LIMIT, for i in {1,2}. If both are starved, rr_ptr picks between them.
2. Requester 0, if valid.
3. Requesters 1 and 2 that are valid. If both are valid, rr_ptr picks between them.

State:
- rr_ptr: 1 bit, 0 means prefer requester 1. After a grant to 1 it is set to 1; after a grant to 2 it is set to 0. A grant to requester 0 leaves it unchanged.
- wait[i], i in {1,2}: 4-bit counter.
  - Cleared when granted, or when req_valid[i]=0.
  - Otherwise incremented, saturating at STARVE_LIMIT.

Command issue, at the edge that ends the grant cycle:
- SRAM_CS_A_N <= 0.
- SRAM_WE_A_N <= ~req_we[g], where g is the granted requester.
- SRAM_ADDR_A and SRAM_WDATA_A are loaded from requester g.
- With no grant: CS_N <= 1 and WE_N <= 1. ADDR_A and WDATA_A hold their previous values.

Response:
- rsp_tag is a one-hot registered copy of {granted read}.
- rsp_valid is rsp_tag delayed one more cycle.
- Writes produce no response.
- rsp_rdata is valid only while rsp_valid is nonzero. Otherwise it is the held SRAM value and don't-care.

The block is fully pipelined: one command per cycle, with no bubbles between consecutive grants.

## Timing
- Reset values (asynchronous):
  - SRAM_CS_A_N = 1, SRAM_WE_A_N = 1
  - SRAM_ADDR_A = 0, SRAM_WDATA_A = 0
  - rsp_tag = 0, rsp_valid = 0
  - wait[1] = wait[2] = 0, rr_ptr = 0
  - req_ready = 0 while sram_rst_n is low
- Read latency:
  - Cycle N: accept.
  - Cycle N+1: CS_N=0 and WE_N=1 on port A.
  - Cycle N+2: rsp_valid[i]=1 and rsp_rdata = Mem[addr].
- Write: SRAM_WE_A_N=0 in cycle N+1. The memory is updated at the end of N+1.
- Read-after-write ordering:
  - A write accepted in cycle N and a read of the same address accepted in cycle N+1, from any requester, returns the new data in cycle N+3.
  - Ordering follows grant order.
- Starvation: if requester 0 is continuously valid and requester 1 becomes valid in cycle 0, requester 1 is granted in cycle STARVE_LIMIT.
- Reset mid-operation: in-flight commands and responses are dropped. No rsp_valid is produced after reset release for a request accepted before reset.

## Test plan
- Reset: assert sram_rst_n=0 mid-stream -> outputs at their reset values immediately; no rsp_valid after release; req_ready=0 throughout reset.
- Single read: req 2 reads addr 0x155 after a prior write of 0xA5A5A5 -> rsp_valid=3'b100 and rsp_rdata=0xA5A5A5 exactly 2 cycles after accept.
- RAW across requesters: req 1 writes 0x123456 to 0x3FF in cycle N, then req 0 reads 0x3FF accepted in cycle N+1 -> rsp_valid=3'b001 with 0x123456 in cycle N+3.
- Starvation: req 0 and req 1 held valid continuously (STARVE_LIMIT=8) -> grant pattern 0 x8, 1, 0 x8, 1 …
- Two starved: reqs 0, 1 and 2 continuously valid -> grants 0 x8, then 1 at cycle 8, 2 at cycle 9, then 0 again.
- Round robin without req 0: reqs 1 and 2 continuously valid -> alternating 1,2,1,2 with back-to-back commands (CS_N low every cycle).

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Port-A arbiter/sequencer for the 1024x24 pixel SRAM: three valid/ready
// clients, fixed priority for client 0, starvation override for 1 and 2.
//
// Ports:
//   sram_clk, sram_rst_n        clock, async active-low reset
//   req_valid/we/addr/wdata     per-client request, packed [i*W +: W]
//   req_ready                   one-hot grant, combinational
//   rsp_valid, rsp_rdata        one-hot read strobe and read data
//   SRAM_*_A                    registered port-A command, read data in
module sram_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 24,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                sram_clk,
    input  logic                sram_rst_n,
    input  logic [2:0]          req_valid,
    input  logic [2:0]          req_we,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_wdata,
    output logic [2:0]          req_ready,
    output logic [2:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                SRAM_CS_A_N,
    output logic                SRAM_WE_A_N,
    output logic [ADDR_W-1:0]   SRAM_ADDR_A,
    output logic [DATA_W-1:0]   SRAM_WDATA_A,
    input  logic [DATA_W-1:0]   SRAM_RDATA_A
);

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic              rr_q, rr_d;
    logic [3:0]        wait1_q, wait1_d;
    logic [3:0]        wait2_q, wait2_d;
    logic              cs_n_q, cs_n_d;
    logic              we_n_q, we_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        tag_q, tag_d;
    logic [2:0]        rsp_q, rsp_d;

    logic              starve1, starve2;
    logic [2:0]        grant;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // Gated with valid so a dropped request can never be granted.
    assign starve1 = req_valid[1] && (wait1_q == LIM);
    assign starve2 = req_valid[2] && (wait2_q == LIM);

    always_comb begin
        grant = 3'b000;
        if (!sram_rst_n) begin
            grant = 3'b000;
        end else if (starve1 && starve2) begin
            grant = rr_q ? 3'b100 : 3'b010;
        end else if (starve1) begin
            grant = 3'b010;
        end else if (starve2) begin
            grant = 3'b100;
        end else if (req_valid[0]) begin
            grant = 3'b001;
        end else if (req_valid[1] && req_valid[2]) begin
            grant = rr_q ? 3'b100 : 3'b010;
        end else if (req_valid[1]) begin
            grant = 3'b010;
        end else if (req_valid[2]) begin
            grant = 3'b100;
        end
    end

    assign req_ready = grant;

    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        unique case (1'b1)
            grant[0]: begin
                g_addr  = req_addr[0*ADDR_W +: ADDR_W];
                g_wdata = req_wdata[0*DATA_W +: DATA_W];
            end
            grant[1]: begin
                g_addr  = req_addr[1*ADDR_W +: ADDR_W];
                g_wdata = req_wdata[1*DATA_W +: DATA_W];
            end
            grant[2]: begin
                g_addr  = req_addr[2*ADDR_W +: ADDR_W];
                g_wdata = req_wdata[2*DATA_W +: DATA_W];
            end
            default: begin
                g_addr  = '0;
                g_wdata = '0;
            end
        endcase
    end

    always_comb begin
        rr_d = rr_q;
        if (grant[1]) begin
            rr_d = 1'b1;
        end else if (grant[2]) begin
            rr_d = 1'b0;
        end

        wait1_d = wait1_q;
        if (grant[1] || !req_valid[1]) begin
            wait1_d = '0;
        end else if (wait1_q != LIM) begin
            wait1_d = wait1_q + 4'd1;
        end

        wait2_d = wait2_q;
        if (grant[2] || !req_valid[2]) begin
            wait2_d = '0;
        end else if (wait2_q != LIM) begin
            wait2_d = wait2_q + 4'd1;
        end

        cs_n_d  = ~(|grant);
        we_n_d  = ~(|(grant & req_we));
        addr_d  = (|grant) ? g_addr  : addr_q;
        wdata_d = (|grant) ? g_wdata : wdata_q;
        // Tag tracks the read through the SRAM's internal output register.
        tag_d   = grant & ~req_we;
        rsp_d   = tag_q;
    end

    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            rr_q    <= 1'b0;
            wait1_q <= '0;
            wait2_q <= '0;
            cs_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            rsp_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            wait1_q <= wait1_d;
            wait2_q <= wait2_d;
            cs_n_q  <= cs_n_d;
            we_n_q  <= we_n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
            rsp_q   <= rsp_d;
        end
    end

    assign SRAM_CS_A_N  = cs_n_q;
    assign SRAM_WE_A_N  = we_n_q;
    assign SRAM_ADDR_A  = addr_q;
    assign SRAM_WDATA_A = wdata_q;
    assign rsp_valid    = rsp_q;
    assign rsp_rdata    = SRAM_RDATA_A;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural
// 1024x24 SRAM (registered read) attached to port A.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_we;
    logic [29:0] req_addr;
    logic [71:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [23:0] rsp_rdata;
    logic        cs_n;
    logic        we_n;
    logic [9:0]  sram_addr;
    logic [23:0] sram_wdata;
    logic [23:0] sram_rdata;

    logic [23:0] mem [0:1023];

    int checks = 0;
    int passed = 0;

    sram_port_arbiter #(
        .ADDR_W(10), .DATA_W(24), .STARVE_LIMIT(8)
    ) dut (
        .sram_clk    (clk),
        .sram_rst_n  (rst_n),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .SRAM_CS_A_N (cs_n),
        .SRAM_WE_A_N (we_n),
        .SRAM_ADDR_A (sram_addr),
        .SRAM_WDATA_A(sram_wdata),
        .SRAM_RDATA_A(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cs_n) begin
            if (!we_n) mem[sram_addr] <= sram_wdata;
            else       sram_rdata <= mem[sram_addr];
        end
    end

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  we;
        logic [29:0] addr;
        logic [71:0] wdata;
        logic [2:0]  exp_ready;
        logic [2:0]  exp_rsp;
        logic [23:0] exp_rdata;
        logic [1:0]  exp_cmd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sram_rdata = '0;
        rst_n      = 1'b0;
        req_valid  = 3'b111;
        req_we     = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        //          valid   we      addr                    wdata
        tbl[0]  = '{3'b100, 3'b100, {10'h155,10'h0,10'h0},
                    {24'hA5A5A5,24'h0,24'h0}, 3'b100, 3'b000, 24'h0, 2'b11};
        tbl[1]  = '{3'b010, 3'b010, {10'h0,10'h3FF,10'h0},
                    {24'h0,24'h123456,24'h0}, 3'b010, 3'b000, 24'h0, 2'b00};
        tbl[2]  = '{3'b001, 3'b000, {10'h0,10'h0,10'h3FF},
                    72'h0, 3'b001, 3'b000, 24'h0, 2'b00};
        tbl[3]  = '{3'b100, 3'b000, {10'h155,10'h0,10'h0},
                    72'h0, 3'b100, 3'b000, 24'h0, 2'b01};
        tbl[4]  = '{3'b000, 3'b000, 30'h0, 72'h0,
                    3'b000, 3'b001, 24'h123456, 2'b01};
        tbl[5]  = '{3'b000, 3'b000, 30'h0, 72'h0,
                    3'b000, 3'b100, 24'hA5A5A5, 2'b11};
        tbl[6]  = '{3'b000, 3'b000, 30'h0, 72'h0,
                    3'b000, 3'b000, 24'h0, 2'b11};
        tbl[7]  = '{3'b110, 3'b000, {10'h3FF,10'h155,10'h0},
                    72'h0, 3'b010, 3'b000, 24'h0, 2'b11};
        tbl[8]  = '{3'b110, 3'b000, {10'h3FF,10'h155,10'h0},
                    72'h0, 3'b100, 3'b000, 24'h0, 2'b01};
        tbl[9]  = '{3'b110, 3'b000, {10'h3FF,10'h155,10'h0},
                    72'h0, 3'b010, 3'b010, 24'hA5A5A5, 2'b01};
        tbl[10] = '{3'b100, 3'b000, {10'h3FF,10'h155,10'h0},
                    72'h0, 3'b100, 3'b100, 24'h123456, 2'b01};
        tbl[11] = '{3'b000, 3'b000, 30'h0, 72'h0,
                    3'b000, 3'b010, 24'hA5A5A5, 2'b01};
        tbl[12] = '{3'b000, 3'b000, 30'h0, 72'h0,
                    3'b000, 3'b100, 24'h123456, 2'b11};
        tbl[13] = '{3'b000, 3'b000, 30'h0, 72'h0,
                    3'b000, 3'b000, 24'h0, 2'b11};

        // Reset state, with all clients requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_cs_n", 32'(cs_n), 32'h1);
        chk("rst_we_n", 32'(we_n), 32'h1);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_wdata", 32'(sram_wdata), 32'h0);
        chk("rst_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 3'b000;
        rst_n = 1'b1;
        next_cycle();

        // Table: writes, RAW across clients, reads, round robin.
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].valid;
            req_we    = tbl[i].we;
            req_addr  = tbl[i].addr;
            req_wdata = tbl[i].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(req_ready),
                32'(tbl[i].exp_ready));
            chk($sformatf("v%0d_rsp", i), 32'(rsp_valid),
                32'(tbl[i].exp_rsp));
            chk($sformatf("v%0d_cmd", i), 32'({cs_n, we_n}),
                32'(tbl[i].exp_cmd));
            if (tbl[i].exp_rsp != 3'b000)
                chk($sformatf("v%0d_rdata", i), 32'(rsp_rdata),
                    32'(tbl[i].exp_rdata));
            next_cycle();
        end

        // Reset while a read is in flight.
        req_valid = 3'b001;
        req_we    = 3'b000;
        req_addr  = {10'h0, 10'h0, 10'h155};
        @(negedge clk);
        chk("mid_accept", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 3'b000;
        chk("mid_cmd_issued", 32'({cs_n, sram_addr}), {21'h0, 1'b0, 10'h155});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_cs_n", 32'(cs_n), 32'h1);
        chk("mid_we_n", 32'(we_n), 32'h1);
        chk("mid_addr", 32'(sram_addr), 32'h0);
        chk("mid_wdata", 32'(sram_wdata), 32'h0);
        chk("mid_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_ready%0d", c), 32'(req_ready), 32'h0);
        end
        req_valid = 3'b000;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rsp%0d", c), 32'(rsp_valid), 32'h0);
        end
        next_cycle();

        // Two starved clients behind client 0.
        req_valid = 3'b111;
        req_we    = 3'b000;
        req_addr  = {10'h3, 10'h2, 10'h1};
        for (int c = 0; c < 12; c++) begin
            logic [2:0] e;
            e = (c == 8) ? 3'b010 : (c == 9) ? 3'b100 : 3'b001;
            @(negedge clk);
            chk($sformatf("two_starve_c%0d", c), 32'(req_ready), 32'(e));
            next_cycle();
        end
        req_valid = 3'b000;
        next_cycle();

        // Client 1 starved behind client 0.
        req_valid = 3'b011;
        for (int c = 0; c < 18; c++) begin
            logic [2:0] e;
            e = (c == 8 || c == 17) ? 3'b010 : 3'b001;
            @(negedge clk);
            chk($sformatf("starve_c%0d", c), 32'(req_ready), 32'(e));
            next_cycle();
        end
        req_valid = 3'b000;
        next_cycle();

        // Round robin between 1 and 2, back-to-back commands.
        req_valid = 3'b110;
        for (int c = 0; c < 6; c++) begin
            logic [2:0] e;
            e = (c % 2 == 0) ? 3'b100 : 3'b010;
            @(negedge clk);
            chk($sformatf("rr_c%0d", c), 32'(req_ready), 32'(e));
            if (c > 0) chk($sformatf("rr_cs_c%0d", c), 32'(cs_n), 32'h0);
            next_cycle();
        end
        req_valid = 3'b000;
        @(negedge clk);
        chk("rr_cs_last", 32'(cs_n), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rr_cs_idle", 32'(cs_n), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
